// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential shift-add multiplier controller.
//   WIDTH  : operand width in bits
//   PROD_W : product width (twice the operand width)
//   CNT_W  : width of the shift-add step counter
//   state_e: controller sequencing states
package mult_pkg;

  localparam int WIDTH  = 8;
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = $clog2(WIDTH);

  // Sequencing states of the multiplier controller
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    SEL  = 3'd3,
    CAPT = 3'd4
  } state_e;

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl
// Sequencing controller for the 8-bit sequential shift-add multiplier
// datapath. It accepts a start request, latches both signed operands, steps
// the datapath through load / shift-add / product-select, stops early once
// the remaining multiplier bits are all zero, and returns the signed product
// together with a one-cycle done pulse.
//
// Ports
//   clk             : rising-edge clock
//   reset           : asynchronous, active-low reset
//   start           : operation request, only looked at while idle
//   a_in, b_in      : two's complement multiplicand / multiplier
//   busy            : operation in flight (LOAD through CAPT)
//   done            : one-cycle pulse, result valid from this cycle on
//   result          : signed product, held until the next done
//   result_sign     : sign of result, held with result
//   dp_multiplicand : registered a_in towards the datapath
//   dp_multiplier   : registered b_in towards the datapath
//   dp_load         : datapath load strobe
//   dp_enable       : datapath shift-add step strobe
//   dp_product_sel  : selects the sign-corrected product in the datapath
//   dp_product      : datapath product register
//   dp_sign         : datapath sign (a xor b)
//   dp_zero_flag    : remaining multiplier bits are all zero
//   dp_b0           : LSB of remaining multiplier, observed only
module mult_ctrl
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] result,
  output logic              result_sign,
  output logic [WIDTH-1:0]  dp_multiplicand,
  output logic [WIDTH-1:0]  dp_multiplier,
  output logic              dp_load,
  output logic              dp_enable,
  output logic              dp_product_sel,
  input  logic [PROD_W-1:0] dp_product,
  input  logic              dp_sign,
  input  logic              dp_zero_flag,
  input  logic              dp_b0
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    stepCnt_q, stepCnt_d;
  logic [WIDTH-1:0]    multiplicand_q, multiplicand_d;
  logic [WIDTH-1:0]    multiplier_q, multiplier_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic                resultSign_q, resultSign_d;
  logic                done_q, done_d;
  logic                dpLoad_q, dpLoad_d;
  logic                productSel_q, productSel_d;
  logic                busy_q, busy_d;
  logic                stepEnable;

  // The LSB of the remaining multiplier is only of interest for monitoring
  logic unusedB0;
  assign unusedB0 = dp_b0;

  // Next-state logic. The shift-add strobe is the only control that reacts
  // to the datapath within the same cycle: it must drop in the very cycle the
  // zero flag rises so no step is wasted after the multiplier is exhausted.
  always_comb begin
    state_d        = state_q;
    stepCnt_d      = stepCnt_q;
    multiplicand_d = multiplicand_q;
    multiplier_d   = multiplier_q;
    result_d       = result_q;
    resultSign_d   = resultSign_q;
    done_d         = 1'b0;
    stepEnable     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          multiplicand_d = a_in;
          multiplier_d   = b_in;
          state_d        = LOAD;
        end
      end

      LOAD: begin
        stepCnt_d = '0;
        state_d   = RUN;
      end

      RUN: begin
        if (dp_zero_flag) begin
          state_d = SEL;
        end else begin
          stepEnable = 1'b1;
          // The counter saturates on the last step instead of wrapping, so
          // at most WIDTH strobes are ever issued.
          if (stepCnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = SEL;
          end else begin
            stepCnt_d = stepCnt_q + CNT_W'(1);
          end
        end
      end

      SEL: begin
        state_d = CAPT;
      end

      CAPT: begin
        result_d     = dp_product;
        resultSign_d = dp_sign;
        done_d       = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes that follow the state are registered from the next state so
    // they line up exactly with the state they belong to.
    dpLoad_d     = (state_d == LOAD);
    productSel_d = (state_d == SEL) || (state_d == CAPT);
    busy_d       = (state_d != IDLE);
  end

  // State, counter, operand and result registers; everything clears on reset
  // so an aborted operation leaves no stale product behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      stepCnt_q      <= '0;
      multiplicand_q <= '0;
      multiplier_q   <= '0;
      result_q       <= '0;
      resultSign_q   <= 1'b0;
      done_q         <= 1'b0;
      dpLoad_q       <= 1'b0;
      productSel_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      stepCnt_q      <= stepCnt_d;
      multiplicand_q <= multiplicand_d;
      multiplier_q   <= multiplier_d;
      result_q       <= result_d;
      resultSign_q   <= resultSign_d;
      done_q         <= done_d;
      dpLoad_q       <= dpLoad_d;
      productSel_q   <= productSel_d;
      busy_q         <= busy_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign result_sign     = resultSign_q;
  assign dp_multiplicand = multiplicand_q;
  assign dp_multiplier   = multiplier_q;
  assign dp_load         = dpLoad_q;
  assign dp_enable       = stepEnable;
  assign dp_product_sel  = productSel_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl
// Directed bench for mult_ctrl. A small behavioural shift-add datapath model
// closes the loop around the controller so both sequencing and end-to-end
// products can be checked against hand-computed values.
module tb_mult_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  aIn;
  logic [7:0]  bIn;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        resultSign;
  logic [7:0]  dpMultiplicand;
  logic [7:0]  dpMultiplier;
  logic        dpLoad;
  logic        dpEnable;
  logic        dpProductSel;
  logic [15:0] dpProduct;
  logic        dpSign;
  logic        dpZeroFlag;
  logic        dpB0;

  int vectorCnt = 0;
  int missCnt   = 0;
  logic [15:0] prevResult = 16'h0000;
  logic        prevSign   = 1'b0;

  mult_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .a_in            (aIn),
    .b_in            (bIn),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .result_sign     (resultSign),
    .dp_multiplicand (dpMultiplicand),
    .dp_multiplier   (dpMultiplier),
    .dp_load         (dpLoad),
    .dp_enable       (dpEnable),
    .dp_product_sel  (dpProductSel),
    .dp_product      (dpProduct),
    .dp_sign         (dpSign),
    .dp_zero_flag    (dpZeroFlag),
    .dp_b0           (dpB0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: magnitudes are multiplied by shift-add, the remaining
  // multiplier is shifted right per step, and the sign is applied on select.
  logic [7:0]  mMcand;
  logic [7:0]  mRem;
  logic [15:0] mAcc;
  logic        mSign;
  logic [3:0]  mStep;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mMcand <= 8'h00;
      mRem   <= 8'h00;
      mAcc   <= 16'h0000;
      mSign  <= 1'b0;
      mStep  <= 4'd0;
    end else if (dpLoad) begin
      mMcand <= dpMultiplicand[7] ? (~dpMultiplicand + 8'd1) : dpMultiplicand;
      mRem   <= dpMultiplier[7] ? (~dpMultiplier + 8'd1) : dpMultiplier;
      mAcc   <= 16'h0000;
      mSign  <= dpMultiplicand[7] ^ dpMultiplier[7];
      mStep  <= 4'd0;
    end else if (dpEnable) begin
      if (mRem[0]) mAcc <= mAcc + ({8'h00, mMcand} << mStep);
      mRem  <= mRem >> 1;
      mStep <= mStep + 4'd1;
    end
  end

  assign dpZeroFlag = (mRem == 8'h00);
  assign dpB0       = mRem[0];
  assign dpSign     = mSign;
  assign dpProduct  = (dpProductSel && mSign) ? (~mAcc + 16'd1) : mAcc;

  // Advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the vector and reports a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCnt++;
    assert (observed === expected)
    else begin
      missCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Run one operation from the start request to done and check its timing
  // and product. With chainNext the start stays high through done so the
  // next call begins back-to-back.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input bit holdStart, input bit chainNext,
                               input int expDone, input int expEn,
                               input logic [15:0] expResult, input logic expSign);
    int cyc;
    int loadCount;
    int loadCycle;
    int enCount;
    int busyCount;
    int selCount;
    int exclBad;
    int heldBad;
    int doneCycle;
    loadCount = 0; loadCycle = -1; enCount = 0; busyCount = 0;
    selCount = 0; exclBad = 0; heldBad = 0; doneCycle = -1;

    aIn = a;
    bIn = b;
    start = 1'b1;
    tick();
    cyc = 1;
    while (1) begin
      if (dpLoad) begin
        loadCount++;
        if (loadCycle < 0) loadCycle = cyc;
      end
      if (dpEnable) enCount++;
      if (dpEnable && dpZeroFlag) exclBad++;
      if ((int'(dpLoad) + int'(dpEnable) + int'(dpProductSel)) > 1) exclBad++;
      if (dpProductSel) selCount++;
      if (busy) busyCount++;
      if (!done && (result !== prevResult || resultSign !== prevSign)) heldBad++;
      if (done && doneCycle < 0) doneCycle = cyc;
      if (!holdStart && cyc == 1) start = 1'b0;
      if (doneCycle >= 0 || cyc >= 30) break;
      tick();
      cyc++;
    end

    checkOutput("load cycle", loadCycle, 1);
    checkOutput("load count", loadCount, 1);
    checkOutput("done cycle", doneCycle, expDone);
    checkOutput("enable count", enCount, expEn);
    checkOutput("busy cycles", busyCount, expDone - 1);
    checkOutput("select cycles", selCount, 2);
    checkOutput("strobe overlap", exclBad, 0);
    checkOutput("result held", heldBad, 0);
    checkOutput("result", {16'h0, result}, {16'h0, expResult});
    checkOutput("result sign", {31'h0, resultSign}, {31'h0, expSign});
    prevResult = expResult;
    prevSign   = expSign;

    if (!chainNext) begin
      start = 1'b0;
      tick();
      checkOutput("done pulse width", {31'h0, done}, 32'h0);
      checkOutput("idle busy", {31'h0, busy}, 32'h0);
      checkOutput("no queued load", {31'h0, dpLoad}, 32'h0);
      checkOutput("result after done", {16'h0, result}, {16'h0, expResult});
    end
  endtask

  // Everything the controller drives must be zero while in reset
  task automatic checkResetState();
    checkOutput("rst busy", {31'h0, busy}, 32'h0);
    checkOutput("rst done", {31'h0, done}, 32'h0);
    checkOutput("rst result", {16'h0, result}, 32'h0);
    checkOutput("rst sign", {31'h0, resultSign}, 32'h0);
    checkOutput("rst load", {31'h0, dpLoad}, 32'h0);
    checkOutput("rst enable", {31'h0, dpEnable}, 32'h0);
    checkOutput("rst select", {31'h0, dpProductSel}, 32'h0);
    checkOutput("rst multiplicand", {24'h0, dpMultiplicand}, 32'h0);
    checkOutput("rst multiplier", {24'h0, dpMultiplier}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    aIn   = 8'h00;
    bIn   = 8'h00;
    #12;
    checkResetState();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 3 * 5: three steps, zero flag at c5, done at c8
    applyStimulus(8'h03, 8'h05, 1'b0, 1'b0, 8, 3, 16'h000F, 1'b0);

    // Abort mid-RUN at c5; the earlier product must be wiped as well
    aIn   = 8'hFD;
    bIn   = 8'h85;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("mid run enable", {31'h0, dpEnable}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkResetState();
    prevResult = 16'h0000;
    prevSign   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // -3 * -123 = 369: seven steps, done at c12
    applyStimulus(8'hFD, 8'h85, 1'b0, 1'b0, 12, 7, 16'h0171, 1'b0);

    // -1 * 127 = -127
    applyStimulus(8'hFF, 8'h7F, 1'b0, 1'b0, 12, 7, 16'hFF81, 1'b1);

    // 2 * -128 = -256: all eight steps, counter limit ends the run
    applyStimulus(8'h02, 8'h80, 1'b0, 1'b0, 12, 8, 16'hFF00, 1'b1);

    // b = 0 with start held while busy: no steps, done at c5
    applyStimulus(8'h5A, 8'h00, 1'b1, 1'b0, 5, 0, 16'h0000, 1'b0);

    // Back-to-back: 7 * 6 = 42, then -16 * 3 = -48 starting in the done cycle
    applyStimulus(8'h07, 8'h06, 1'b1, 1'b1, 8, 3, 16'h002A, 1'b0);
    applyStimulus(8'hF0, 8'h03, 1'b0, 1'b0, 7, 2, 16'hFFD0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
    $finish;
  end

endmodule
